layer_scheduler: RTL and testbench
==================================

LAYER_SCHEDULER -- requirements
Module: layer_scheduler

Interface
REQ-001 SHALL have parameter IMG_W, default 8, the width of the image counter.
REQ-002 SHALL have parameter WDT_W, default 20, the width of the watchdog counter.
REQ-003 SHALL have parameter WDT_LIMIT, default 20'hFFFFF, the maximum cycles spent in any wait state.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-005 SHALL have port srst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port start, input, 1 bit: request to run a batch.
REQ-007 SHALL have port num_img, input, IMG_W bits: number of images in the batch, sampled on accepted start.
REQ-008 SHALL have port abort, input, 1 bit: cancel the running batch.
REQ-009 SHALL have port conv_start, output, 1 bit: one-cycle pulse to the conv engine.
REQ-010 SHALL have port conv_done, input, 1 bit: conv engine completion.
REQ-011 SHALL have port fc1_start, output, 1 bit: one-cycle pulse to FC1.
REQ-012 SHALL have port fc1_done, input, 1 bit: FC1 completion.
REQ-013 SHALL have port fc2_start, output, 1 bit: one-cycle pulse to FC2.
REQ-014 SHALL have port fc2_done, input, 1 bit: FC2 completion.
REQ-015 SHALL have port mem_sel, output, 1 bit: ping-pong input-buffer select.
REQ-016 SHALL have port busy, output, 1 bit: high in every state except IDLE and ERR.
REQ-017 SHALL have port img_cnt, output, IMG_W bits: number of images completed in the current batch.
REQ-018 SHALL have port batch_done, output, 1 bit: one-cycle pulse when the batch finishes.
REQ-019 SHALL have port timeout, output, 1 bit: sticky watchdog error flag.

Function
REQ-020 SHALL implement the FSM states IDLE, CONV_GO, CONV_WAIT, FC1_GO, FC1_WAIT, FC2_GO, FC2_WAIT, NEXT, FINISH and ERR.
REQ-021 SHALL, in IDLE with start=1 and num_img!=0, latch num_img, clear img_cnt and enter CONV_GO on the next cycle.
REQ-022 SHALL, in IDLE with start=1 and num_img=0, enter FINISH without issuing any start pulse.
REQ-023 SHALL ignore start in every state other than IDLE.
REQ-024 SHALL drive conv_start=1 only in CONV_GO, fc1_start=1 only in FC1_GO and fc2_start=1 only in FC2_GO; each GO state lasts exactly 1 cycle and moves to its WAIT state.
REQ-025 SHALL sample each done input only in its own WAIT state, so that done seen in GO or in another state is ignored.
REQ-026 SHALL, on the matching done in a WAIT state, advance on the next cycle: CONV_WAIT to FC1_GO, FC1_WAIT to FC2_GO, FC2_WAIT to NEXT.
REQ-027 SHALL, in NEXT (1 cycle), increment img_cnt and toggle mem_sel; it then enters FINISH if the incremented img_cnt equals the latched count, otherwise CONV_GO.
REQ-028 SHALL hold latency from fcX_done to the next start pulse at exactly 1 cycle, and from fc2_done to the next conv_start at exactly 2 cycles.
REQ-029 SHALL pulse batch_done for exactly 1 cycle in FINISH and then return to IDLE; img_cnt holds its final value until the next accepted start.
REQ-030 SHALL clear the WDT_W-bit watchdog on entry to each WAIT state and increment it each cycle in that WAIT state without its done.
REQ-031 SHALL, when the watchdog reaches WDT_LIMIT, enter ERR and set timeout=1.
REQ-032 SHALL have priority done over timeout when both occur in the same cycle.
REQ-033 SHALL hold ERR and timeout until srst, with no start pulses and start ignored.
REQ-034 SHALL, on abort=1 in any state except IDLE and ERR, go to IDLE on the next cycle with no batch_done; mem_sel and img_cnt keep their values.
REQ-035 SHALL have priority abort over done and watchdog when they occur in the same cycle.
REQ-036 SHALL wrap img_cnt modulo 2^IMG_W; because the latched count is at most 2^IMG_W-1, the wrap is unreachable in normal operation.

Reset
REQ-037 SHALL, on srst=1 at a clock edge, enter IDLE and set conv_start=fc1_start=fc2_start=0, mem_sel=0, busy=0, img_cnt=0, batch_done=0, timeout=0 and watchdog=0; this applies mid-operation and takes priority over all other inputs.

Verification
REQ-038 SHALL cover a single image: num_img=1, start, each done returned 5 cycles after its start -> start pulses in order conv, fc1, fc2, each 1 cycle; then img_cnt=1, mem_sel=1 and batch_done 1 cycle after NEXT.
REQ-039 SHALL cover a batch: num_img=3, done returned after 2 cycles -> 3 conv_start pulses; mem_sel sequence 0,1,0,1; img_cnt 1,2,3; one batch_done; conv_start exactly 2 cycles after each fc2_done.
REQ-040 SHALL cover the empty batch: num_img=0, start -> no start pulses; batch_done pulses the cycle after FINISH entry; img_cnt=0.
REQ-041 SHALL cover the watchdog: WDT_LIMIT=16 and conv_done withheld -> ERR with timeout=1 and busy=0 after 16 cycles in CONV_WAIT; later start ignored; srst clears timeout.
REQ-042 SHALL cover abort against done: abort and fc1_done asserted together in FC1_WAIT -> IDLE next cycle, no fc2_start, no batch_done.
REQ-043 SHALL cover spurious inputs: start while busy, and conv_done asserted during FC1_WAIT -> no effect on state or counters; srst asserted mid-batch -> all outputs at reset values the next cycle.

Source files
------------

// File: rtl/layer_scheduler.sv
// Sequences conv -> fc1 -> fc2 per image over a batch, with ping-pong buffer select,
// per-wait-state watchdog, abort and a sticky timeout error state.
module layer_scheduler #(
  parameter int               IMG_W     = 8,
  parameter int               WDT_W     = 20,
  parameter logic [WDT_W-1:0] WDT_LIMIT = 20'hFFFFF
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             start,
  input  logic [IMG_W-1:0] num_img,
  input  logic             abort,
  output logic             conv_start,
  input  logic             conv_done,
  output logic             fc1_start,
  input  logic             fc1_done,
  output logic             fc2_start,
  input  logic             fc2_done,
  output logic             mem_sel,
  output logic             busy,
  output logic [IMG_W-1:0] img_cnt,
  output logic             batch_done,
  output logic             timeout
);

  typedef enum logic [3:0] {
    IDLE, CONV_GO, CONV_WAIT, FC1_GO, FC1_WAIT, FC2_GO, FC2_WAIT, NEXT, FINISH, ERR
  } state_t;

  state_t           state_q, state_d;
  logic [WDT_W-1:0] wdt_q, wdt_d, wdt_inc;
  logic [IMG_W-1:0] num_q, num_d;
  logic [IMG_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             mem_sel_q, mem_sel_d;
  logic             timeout_q, timeout_d;
  logic             conv_start_q, conv_start_d;
  logic             fc1_start_q, fc1_start_d;
  logic             fc2_start_q, fc2_start_d;
  logic             busy_q, busy_d;
  logic             batch_done_q, batch_done_d;
  logic             wait_done;

  assign wdt_inc = wdt_q + 1'b1;
  assign cnt_inc = cnt_q + 1'b1;

  // Only the done belonging to the current wait state counts; all others are ignored.
  assign wait_done = ((state_q == CONV_WAIT) && conv_done) ||
                     ((state_q == FC1_WAIT)  && fc1_done)  ||
                     ((state_q == FC2_WAIT)  && fc2_done);

  always_comb begin
    state_d   = state_q;
    wdt_d     = wdt_q;
    num_d     = num_q;
    cnt_d     = cnt_q;
    mem_sel_d = mem_sel_q;
    timeout_d = timeout_q;

    if (abort && (state_q != IDLE) && (state_q != ERR)) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            cnt_d = '0;
            if (num_img != '0) begin
              num_d   = num_img;
              state_d = CONV_GO;
            end else begin
              state_d = FINISH;
            end
          end
        end
        CONV_GO: begin state_d = CONV_WAIT; wdt_d = '0; end
        FC1_GO:  begin state_d = FC1_WAIT;  wdt_d = '0; end
        FC2_GO:  begin state_d = FC2_WAIT;  wdt_d = '0; end
        CONV_WAIT, FC1_WAIT, FC2_WAIT: begin
          if (wait_done) begin
            state_d = (state_q == CONV_WAIT) ? FC1_GO :
                      (state_q == FC1_WAIT)  ? FC2_GO : NEXT;
          end else begin
            wdt_d = wdt_inc;
            if (wdt_inc == WDT_LIMIT) begin
              state_d   = ERR;
              timeout_d = 1'b1;
            end
          end
        end
        NEXT: begin
          cnt_d     = cnt_inc;
          mem_sel_d = ~mem_sel_q;
          state_d   = (cnt_inc == num_q) ? FINISH : CONV_GO;
        end
        FINISH:  state_d = IDLE;
        ERR:     state_d = ERR;
        default: state_d = IDLE;
      endcase
    end

    // Outputs are registered decodes of the next state so they align with the state.
    conv_start_d = (state_d == CONV_GO);
    fc1_start_d  = (state_d == FC1_GO);
    fc2_start_d  = (state_d == FC2_GO);
    busy_d       = (state_d != IDLE) && (state_d != ERR);
    batch_done_d = (state_d == FINISH);
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q      <= IDLE;
      wdt_q        <= '0;
      cnt_q        <= '0;
      mem_sel_q    <= 1'b0;
      timeout_q    <= 1'b0;
      conv_start_q <= 1'b0;
      fc1_start_q  <= 1'b0;
      fc2_start_q  <= 1'b0;
      busy_q       <= 1'b0;
      batch_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wdt_q        <= wdt_d;
      cnt_q        <= cnt_d;
      mem_sel_q    <= mem_sel_d;
      timeout_q    <= timeout_d;
      conv_start_q <= conv_start_d;
      fc1_start_q  <= fc1_start_d;
      fc2_start_q  <= fc2_start_d;
      busy_q       <= busy_d;
      batch_done_q <= batch_done_d;
    end
    num_q <= num_d;
  end

  assign conv_start = conv_start_q;
  assign fc1_start  = fc1_start_q;
  assign fc2_start  = fc2_start_q;
  assign mem_sel    = mem_sel_q;
  assign busy       = busy_q;
  assign img_cnt    = cnt_q;
  assign batch_done = batch_done_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_layer_scheduler.sv
// Directed bench for layer_scheduler: a cycle-by-cycle vector table plus
// hand-written batch, watchdog, abort and mid-batch reset sequences.
module tb_layer_scheduler;

  logic       clk = 1'b0;
  logic       srst, start, abort, conv_done, fc1_done, fc2_done;
  logic [7:0] num_img;
  logic       conv_start, fc1_start, fc2_start, mem_sel, busy, batch_done, timeout;
  logic [7:0] img_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  layer_scheduler #(.IMG_W(8), .WDT_W(20), .WDT_LIMIT(20'd16)) dut (
    .clk(clk), .srst(srst), .start(start), .num_img(num_img), .abort(abort),
    .conv_start(conv_start), .conv_done(conv_done),
    .fc1_start(fc1_start), .fc1_done(fc1_done),
    .fc2_start(fc2_start), .fc2_done(fc2_done),
    .mem_sel(mem_sel), .busy(busy), .img_cnt(img_cnt),
    .batch_done(batch_done), .timeout(timeout)
  );

  typedef struct {
    logic       srst, start;
    logic [7:0] num;
    logic       abort, cd, f1d, f2d;
    logic       cs, f1s, f2s, ms, bsy, bd, to;
    logic [7:0] cnt;
  } vec_t;

  vec_t vecs[17];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    srst = 0; start = 0; num_img = 0; abort = 0;
    conv_done = 0; fc1_done = 0; fc2_done = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    srst = 1;
    tick();
    srst = 0;
  endtask

  // Runs one image from its CONV_GO cycle; done is returned 'dly' cycles after each start.
  task automatic run_image(input string tag, input logic exp_ms, input int dly);
    chk({tag, "_conv_start"}, conv_start, 1);
    chk({tag, "_mem_sel"}, mem_sel, exp_ms);
    repeat (dly) tick();
    chk({tag, "_no_fc1_early"}, fc1_start, 0);
    conv_done = 1; tick(); conv_done = 0;
    chk({tag, "_fc1_start"}, {conv_start, fc1_start, fc2_start}, 3'b010);
    repeat (dly) tick();
    fc1_done = 1; tick(); fc1_done = 0;
    chk({tag, "_fc2_start"}, {conv_start, fc1_start, fc2_start}, 3'b001);
    repeat (dly) tick();
    fc2_done = 1; tick(); fc2_done = 0;
    chk({tag, "_next_quiet"}, {conv_start, fc1_start, fc2_start, batch_done, busy}, 5'b00001);
  endtask

  initial begin
    //            srst st num    ab cd f1 f2   cs f1s f2s ms bsy bd to cnt
    vecs[0]  = '{1, 0, 8'd0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 8'd0};
    vecs[1]  = '{0, 0, 8'd0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 8'd0};
    vecs[2]  = '{0, 1, 8'd0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 1, 0, 8'd0};
    vecs[3]  = '{0, 0, 8'd0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 8'd0};
    vecs[4]  = '{0, 1, 8'd1, 0, 0, 0, 0,   1, 0, 0, 0, 1, 0, 0, 8'd0};
    vecs[5]  = '{0, 0, 8'd0, 0, 1, 0, 0,   0, 0, 0, 0, 1, 0, 0, 8'd0};
    vecs[6]  = '{0, 0, 8'd0, 0, 1, 0, 0,   0, 1, 0, 0, 1, 0, 0, 8'd0};
    vecs[7]  = '{0, 1, 8'd5, 0, 1, 0, 0,   0, 0, 0, 0, 1, 0, 0, 8'd0};
    vecs[8]  = '{0, 0, 8'd0, 0, 1, 0, 0,   0, 0, 0, 0, 1, 0, 0, 8'd0};
    vecs[9]  = '{0, 0, 8'd0, 0, 0, 1, 0,   0, 0, 1, 0, 1, 0, 0, 8'd0};
    vecs[10] = '{0, 0, 8'd0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 0, 0, 8'd0};
    vecs[11] = '{0, 0, 8'd0, 0, 0, 0, 1,   0, 0, 0, 0, 1, 0, 0, 8'd0};
    vecs[12] = '{0, 0, 8'd0, 0, 0, 0, 0,   0, 0, 0, 1, 1, 1, 0, 8'd1};
    vecs[13] = '{0, 0, 8'd0, 0, 0, 0, 0,   0, 0, 0, 1, 0, 0, 0, 8'd1};
    vecs[14] = '{0, 1, 8'd0, 0, 0, 0, 0,   0, 0, 0, 1, 1, 1, 0, 8'd0};
    vecs[15] = '{0, 0, 8'd0, 0, 0, 0, 0,   0, 0, 0, 1, 0, 0, 0, 8'd0};
    vecs[16] = '{1, 1, 8'd3, 1, 1, 1, 1,   0, 0, 0, 0, 0, 0, 0, 8'd0};

    idle_inputs();
    srst = 1;
    #1;

    for (int i = 0; i < 17; i++) begin
      srst = vecs[i].srst; start = vecs[i].start; num_img = vecs[i].num;
      abort = vecs[i].abort; conv_done = vecs[i].cd;
      fc1_done = vecs[i].f1d; fc2_done = vecs[i].f2d;
      tick();
      chk($sformatf("vec%0d", i),
          {conv_start, fc1_start, fc2_start, mem_sel, busy, batch_done, timeout, img_cnt},
          {vecs[i].cs, vecs[i].f1s, vecs[i].f2s, vecs[i].ms, vecs[i].bsy,
           vecs[i].bd, vecs[i].to, vecs[i].cnt});
    end
    idle_inputs();

    // Single image, done returned 5 cycles after each start.
    do_reset();
    start = 1; num_img = 1; tick(); start = 0; num_img = 0;
    run_image("single", 1'b0, 5);
    tick();
    chk("single_finish", {batch_done, img_cnt, mem_sel, conv_start}, {1'b1, 8'd1, 1'b1, 1'b0});
    tick();
    chk("single_idle", {batch_done, busy, img_cnt}, {1'b0, 1'b0, 8'd1});

    // Batch of three, conv_start two cycles after each fc2_done.
    do_reset();
    start = 1; num_img = 3; tick(); start = 0; num_img = 0;
    for (int i = 0; i < 3; i++) begin
      run_image($sformatf("batch%0d", i), logic'(i % 2), 2);
      chk($sformatf("batch%0d_cnt_in_next", i), img_cnt, i);
      tick();
      chk($sformatf("batch%0d_cnt", i), img_cnt, i + 1);
      chk($sformatf("batch%0d_ms_after", i), mem_sel, logic'((i + 1) % 2));
      if (i < 2) chk($sformatf("batch%0d_bd_low", i), batch_done, 0);
    end
    chk("batch_done_pulse", {batch_done, conv_start}, 2'b10);
    tick();
    chk("batch_done_single", {batch_done, busy, img_cnt}, {1'b0, 1'b0, 8'd3});

    // Watchdog: conv_done withheld for 16 cycles in CONV_WAIT.
    do_reset();
    start = 1; num_img = 1; tick(); start = 0; num_img = 0;
    tick();
    repeat (15) tick();
    chk("wdt_before_limit", {busy, timeout}, 2'b10);
    tick();
    chk("wdt_err", {busy, timeout}, 2'b01);
    start = 1; num_img = 2; conv_done = 1; tick();
    chk("wdt_err_ignores_start", {conv_start, busy, timeout}, 3'b001);
    tick(); start = 0; conv_done = 0;
    chk("wdt_err_holds", {conv_start, fc1_start, busy, timeout}, 4'b0001);
    srst = 1; tick(); srst = 0;
    chk("wdt_srst_clears", {busy, timeout}, 2'b00);

    // Abort together with fc1_done in FC1_WAIT.
    do_reset();
    start = 1; num_img = 2; tick(); start = 0; num_img = 0;
    tick();
    conv_done = 1; tick(); conv_done = 0;
    tick();
    abort = 1; fc1_done = 1; tick(); abort = 0; fc1_done = 0;
    chk("abort_idle", {busy, fc2_start, batch_done}, 3'b000);
    tick();
    chk("abort_quiet", {busy, fc2_start, batch_done, img_cnt, mem_sel}, {3'b000, 8'd0, 1'b0});

    // Reset in the middle of a batch after one image completed.
    do_reset();
    start = 1; num_img = 3; tick(); start = 0; num_img = 0;
    run_image("mid", 1'b0, 1);
    tick();
    chk("mid_second_conv", {conv_start, img_cnt, mem_sel}, {1'b1, 8'd1, 1'b1});
    srst = 1; tick(); srst = 0;
    chk("mid_srst",
        {conv_start, fc1_start, fc2_start, mem_sel, busy, batch_done, timeout, img_cnt},
        15'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
